key_entry_lock: RTL and testbench
=================================

KEY_ENTRY_LOCK -- requirements
Module: key_entry_lock

Interface
REQ-001 Parameter PW_LEN, default 4; number of digits in a passcode.
REQ-002 Parameter DEFAULT_PW, default 16'h1234; passcode loaded at reset, one BCD nibble per digit, MS digit first.
REQ-003 Parameter MAX_FAIL, default 3; consecutive failed attempts that trigger lockout.
REQ-004 Parameter OPEN_CYCLES, default 24'd5_000_000; unlock hold time in clk cycles.
REQ-005 Parameter LOCK_CYCLES, default 24'd10_000_000; lockout duration in clk cycles.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 key_valid  in  1  one-cycle strobe marking a new key press (driven by the keypad scanner's keyboard_en).
REQ-009 key_code  in  4  key value, valid only while key_valid=1: 0-9 digits, A-D letters, E='*', F='#'.
REQ-010 unlocked  out  1  high while in OPEN.
REQ-011 alarm  out  1  high while in LOCKOUT.
REQ-012 state  out  2  FSM state: ENTRY=0, OPEN=1, SETPW=2, LOCKOUT=3.
REQ-013 entry  out  16  digit buffer for the display stage; newest digit in [3:0].
REQ-014 digit_cnt  out  3  number of digits currently held, 0..PW_LEN.
REQ-015 fail_cnt  out  2  consecutive failed attempts.
REQ-016 err_pulse  out  1  one-cycle pulse on a rejected '#'.
REQ-017 set_done  out  1  one-cycle pulse when a new passcode is stored.

Function
REQ-018 All outputs shall be registered; every response shall appear on the cycle after the key_valid cycle that causes it.
REQ-019 Keys shall be sampled only when key_valid=1; key_code shall be ignored at all other times.
REQ-020 Digit entry, ENTRY/SETPW, digit_cnt<PW_LEN: entry <= {entry[11:0], key_code}, digit_cnt+1; when digit_cnt=PW_LEN: digit ignored, buffer unchanged.
REQ-021 '*' in ENTRY/SETPW: entry<=0 and digit_cnt<=0; state unchanged.
REQ-022 ENTRY '#', digit_cnt=PW_LEN, entry=stored pw: go to OPEN; timer<=OPEN_CYCLES; fail_cnt<=0; buffer cleared.
REQ-023 ENTRY '#', otherwise (short entry or mismatch): err_pulse=1, fail_cnt+1, buffer cleared; if the new fail_cnt=MAX_FAIL: go to LOCKOUT, timer<=LOCK_CYCLES.
REQ-024 Letters A-D shall be ignored in ENTRY.
REQ-025 OPEN: timer decrements each cycle; at 0 go to ENTRY; '#' or '*' relocks to ENTRY immediately.
REQ-026 OPEN, key A: go to SETPW; buffer cleared; timer held.
REQ-027 Other keys in OPEN shall be ignored.
REQ-028 SETPW, '#' with digit_cnt=PW_LEN: pw<=entry, set_done=1, go to ENTRY.
REQ-029 SETPW, '#' with digit_cnt<PW_LEN: err_pulse=1, stay in SETPW; fail_cnt unchanged.
REQ-030 SETPW, key B: abort to ENTRY, pw unchanged; buffer cleared on every exit from SETPW.
REQ-031 LOCKOUT: all keys discarded; timer decrements each cycle; at 0 go to ENTRY with fail_cnt<=0.
REQ-032 If timer expiry and key_valid occur in the same cycle, expiry shall win and the key shall be discarded.
REQ-033 The timer shall be 24 bits; OPEN_CYCLES and LOCK_CYCLES shall each be at least 1.

Reset
REQ-034 When reset=0 at a clk edge, the block shall set: state=ENTRY, pw=DEFAULT_PW, entry=0, digit_cnt=0, fail_cnt=0, timer=0, and all pulse and flag outputs to 0.
REQ-035 Reset shall take priority over key_valid and may interrupt any state, including mid-SETPW (new passcode discarded).

Verification
REQ-036 Keys 1,2,3,4,'#' after reset -> unlocked=1 and state=1 on the cycle after '#'; unlocked=0 after OPEN_CYCLES.
REQ-037 Keys 1,2,3,5,'#' three times -> err_pulse each time, fail_cnt 1,2,3; alarm=1, state=3; keys ignored; ENTRY after LOCK_CYCLES.
REQ-038 Keys 1,2,3,4,5 -> entry=16'h1234, digit_cnt=4 (fifth digit dropped); then '*' -> entry=0, digit_cnt=0.
REQ-039 Unlock, then A,9,8,7,6,'#' -> set_done=1 and state=0; then 9,8,7,6,'#' -> unlocked=1, and 1,2,3,4,'#' -> err_pulse=1.
REQ-040 key_valid asserted on the exact OPEN expiry cycle -> key discarded, state=0; reset=0 during SETPW -> pw reverts to 16'h1234.

Source files
------------

// File: rtl/key_entry_lock_if.sv
// key_entry_lock_if: key strobe input and status outputs of the keypad lock.
//   key_valid  one-cycle strobe marking a new key press
//   key_code   key value (0-9 digits, A-D letters, E='*', F='#')
//   unlocked   high while the lock is open
//   alarm      high while in lockout
//   state      FSM state (ENTRY=0, OPEN=1, SETPW=2, LOCKOUT=3)
//   entry      digit buffer, newest digit in [3:0]
//   digit_cnt  number of digits held
//   fail_cnt   consecutive failed attempts
//   err_pulse  one-cycle pulse on a rejected '#'
//   set_done   one-cycle pulse when a new passcode is stored
interface key_entry_lock_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  state;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic [1:0]  fail_cnt;
  logic        err_pulse;
  logic        set_done;

  // Keypad / host side
  modport master (
    output key_valid, key_code,
    input  unlocked, alarm, state, entry, digit_cnt, fail_cnt, err_pulse, set_done
  );

  // Lock side
  modport slave (
    input  key_valid, key_code,
    output unlocked, alarm, state, entry, digit_cnt, fail_cnt, err_pulse, set_done
  );
endinterface

// File: rtl/key_entry_lock.sv
// key_entry_lock: keypad passcode lock with unlock hold, passcode change and
// lockout after repeated failures. All outputs are registered.
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    key_entry_lock_if.slave (key strobe in, status out)
module key_entry_lock #(
  parameter int unsigned PW_LEN      = 4,
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned MAX_FAIL    = 3,
  parameter logic [23:0] OPEN_CYCLES = 24'd5_000_000,
  parameter logic [23:0] LOCK_CYCLES = 24'd10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  key_entry_lock_if.slave     bus
);

  localparam int unsigned TIMER_W = 24;
  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned FAIL_W  = 2;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_SETPW   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t               r_state;
  logic [ENTRY_W-1:0]   r_pw;
  logic [ENTRY_W-1:0]   r_entry;
  logic [CNT_W-1:0]     r_digit_cnt;
  logic [FAIL_W-1:0]    r_fail_cnt;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_err_pulse;
  logic                 r_set_done;
  logic                 r_unlocked;
  logic                 r_alarm;

  state_t               w_state_nxt;
  logic [ENTRY_W-1:0]   w_pw_nxt;
  logic [ENTRY_W-1:0]   w_entry_nxt;
  logic [CNT_W-1:0]     w_digit_cnt_nxt;
  logic [FAIL_W-1:0]    w_fail_cnt_nxt;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic                 w_err_nxt;
  logic                 w_set_done_nxt;

  logic                 w_is_digit;
  logic                 w_is_star;
  logic                 w_is_hash;
  logic                 w_buf_full;
  logic                 w_expire;
  logic [FAIL_W-1:0]    w_fail_inc;
  logic [ENTRY_W-1:0]   w_entry_shift;

  assign w_is_digit    = (bus.key_code <= 4'd9);
  assign w_is_star     = (bus.key_code == KEY_STAR);
  assign w_is_hash     = (bus.key_code == KEY_HASH);
  assign w_buf_full    = (r_digit_cnt == CNT_W'(PW_LEN));
  // Timer reaching zero this cycle; the state spends exactly N cycles when loaded with N.
  assign w_expire      = (r_timer <= TIMER_W'(1));
  assign w_fail_inc    = r_fail_cnt + FAIL_W'(1);
  assign w_entry_shift = {r_entry[ENTRY_W-5:0], bus.key_code};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_ENTRY;
      r_pw        <= DEFAULT_PW;
      r_entry     <= '0;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_timer     <= '0;
      r_err_pulse <= 1'b0;
      r_set_done  <= 1'b0;
      r_unlocked  <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pw        <= w_pw_nxt;
      r_entry     <= w_entry_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_err_pulse <= w_err_nxt;
      r_set_done  <= w_set_done_nxt;
      r_unlocked  <= (w_state_nxt == ST_OPEN);
      r_alarm     <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_pw_nxt        = r_pw;
    w_entry_nxt     = r_entry;
    w_digit_cnt_nxt = r_digit_cnt;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_timer_nxt     = r_timer;
    w_err_nxt       = 1'b0;
    w_set_done_nxt  = 1'b0;

    case (r_state)
      ST_ENTRY: begin
        if (bus.key_valid) begin
          if (w_is_digit) begin
            if (!w_buf_full) begin
              w_entry_nxt     = w_entry_shift;
              w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
            end
          end else if (w_is_star) begin
            w_entry_nxt     = '0;
            w_digit_cnt_nxt = '0;
          end else if (w_is_hash) begin
            w_entry_nxt     = '0;
            w_digit_cnt_nxt = '0;
            if (w_buf_full && (r_entry == r_pw)) begin
              w_state_nxt    = ST_OPEN;
              w_timer_nxt    = OPEN_CYCLES;
              w_fail_cnt_nxt = '0;
            end else begin
              w_err_nxt      = 1'b1;
              w_fail_cnt_nxt = w_fail_inc;
              if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                w_state_nxt = ST_LOCKOUT;
                w_timer_nxt = LOCK_CYCLES;
              end
            end
          end
        end
      end

      ST_OPEN: begin
        // Expiry takes precedence over a key arriving in the same cycle.
        if (w_expire) begin
          w_state_nxt = ST_ENTRY;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
          if (bus.key_valid) begin
            if (w_is_hash || w_is_star) begin
              w_state_nxt = ST_ENTRY;
              w_timer_nxt = '0;
            end else if (bus.key_code == KEY_A) begin
              w_state_nxt     = ST_SETPW;
              w_timer_nxt     = r_timer;
              w_entry_nxt     = '0;
              w_digit_cnt_nxt = '0;
            end
          end
        end
      end

      ST_SETPW: begin
        if (bus.key_valid) begin
          if (w_is_digit) begin
            if (!w_buf_full) begin
              w_entry_nxt     = w_entry_shift;
              w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
            end
          end else if (w_is_star) begin
            w_entry_nxt     = '0;
            w_digit_cnt_nxt = '0;
          end else if (w_is_hash) begin
            if (w_buf_full) begin
              w_pw_nxt        = r_entry;
              w_set_done_nxt  = 1'b1;
              w_state_nxt     = ST_ENTRY;
              w_timer_nxt     = '0;
              w_entry_nxt     = '0;
              w_digit_cnt_nxt = '0;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (bus.key_code == KEY_B) begin
            w_state_nxt     = ST_ENTRY;
            w_timer_nxt     = '0;
            w_entry_nxt     = '0;
            w_digit_cnt_nxt = '0;
          end
        end
      end

      ST_LOCKOUT: begin
        if (w_expire) begin
          w_state_nxt    = ST_ENTRY;
          w_timer_nxt    = '0;
          w_fail_cnt_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  assign bus.unlocked  = r_unlocked;
  assign bus.alarm     = r_alarm;
  assign bus.state     = r_state;
  assign bus.entry     = r_entry;
  assign bus.digit_cnt = r_digit_cnt;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.err_pulse = r_err_pulse;
  assign bus.set_done  = r_set_done;

endmodule

// File: tb/tb_key_entry_lock.sv
// tb_key_entry_lock: directed bench for key_entry_lock with short timers.
// Keys are driven at the falling edge; outputs are sampled at the next falling
// edge, i.e. half a cycle after the rising edge that consumed the key.
module tb_key_entry_lock;

  localparam logic [23:0] T_OPEN = 24'd8;
  localparam logic [23:0] T_LOCK = 24'd12;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  key_entry_lock_if u_if ();

  key_entry_lock #(
    .PW_LEN      (4),
    .DEFAULT_PW  (16'h1234),
    .MAX_FAIL    (3),
    .OPEN_CYCLES (T_OPEN),
    .LOCK_CYCLES (T_LOCK)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One key press: called at a falling edge, returns at the next falling edge.
  task automatic press(input logic [3:0] code);
    u_if.key_valid = 1'b1;
    u_if.key_code  = code;
    @(negedge clk);
    u_if.key_valid = 1'b0;
    u_if.key_code  = 4'h0;
  endtask

  task automatic press4(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    u_if.key_valid = 1'b0;
    u_if.key_code  = 4'h0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_state", 32'(u_if.state), 32'd0);
    chk("rst_entry", 32'(u_if.entry), 32'd0);
    chk("rst_cnt", 32'(u_if.digit_cnt), 32'd0);
    chk("rst_fail", 32'(u_if.fail_cnt), 32'd0);
    chk("rst_unl", 32'(u_if.unlocked), 32'd0);
    chk("rst_alarm", 32'(u_if.alarm), 32'd0);
    chk("rst_err", 32'(u_if.err_pulse), 32'd0);
    chk("rst_setd", 32'(u_if.set_done), 32'd0);

    // Digit buffering, overflow drop, letters ignored, clear
    press(4'h1);
    chk("buf1_entry", 32'(u_if.entry), 32'h0001);
    chk("buf1_cnt", 32'(u_if.digit_cnt), 32'd1);
    press(4'hC);
    chk("letter_entry", 32'(u_if.entry), 32'h0001);
    press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("full_entry", 32'(u_if.entry), 32'h1234);
    chk("full_cnt", 32'(u_if.digit_cnt), 32'd4);
    press(4'hE);
    chk("star_entry", 32'(u_if.entry), 32'h0000);
    chk("star_cnt", 32'(u_if.digit_cnt), 32'd0);
    chk("star_state", 32'(u_if.state), 32'd0);

    // Unlock and hold for exactly T_OPEN cycles
    press4(16'h1234); press(4'hF);
    chk("unl_unl", 32'(u_if.unlocked), 32'd1);
    chk("unl_state", 32'(u_if.state), 32'd1);
    chk("unl_entry", 32'(u_if.entry), 32'd0);
    repeat (int'(T_OPEN) - 1) @(negedge clk);
    chk("hold_last", 32'(u_if.unlocked), 32'd1);
    @(negedge clk);
    chk("hold_exp", 32'(u_if.unlocked), 32'd0);
    chk("hold_exp_st", 32'(u_if.state), 32'd0);

    // '*' relocks immediately
    press4(16'h1234); press(4'hF);
    press(4'hE);
    chk("relock_st", 32'(u_if.state), 32'd0);
    chk("relock_unl", 32'(u_if.unlocked), 32'd0);

    // Key on the exact expiry cycle is discarded
    press4(16'h1234); press(4'hF);
    repeat (int'(T_OPEN) - 1) @(negedge clk);
    chk("coll_pre", 32'(u_if.state), 32'd1);
    press(4'hA);
    chk("coll_st", 32'(u_if.state), 32'd0);
    @(negedge clk);
    chk("coll_st2", 32'(u_if.state), 32'd0);

    // Three failures lead to lockout
    press4(16'h1235); press(4'hF);
    chk("f1_err", 32'(u_if.err_pulse), 32'd1);
    chk("f1_cnt", 32'(u_if.fail_cnt), 32'd1);
    press(4'h1);
    chk("f1_errclr", 32'(u_if.err_pulse), 32'd0);
    press(4'h2); press(4'h3); press(4'h5); press(4'hF);
    chk("f2_err", 32'(u_if.err_pulse), 32'd1);
    chk("f2_cnt", 32'(u_if.fail_cnt), 32'd2);
    chk("f2_state", 32'(u_if.state), 32'd0);
    press4(16'h1235); press(4'hF);
    chk("f3_err", 32'(u_if.err_pulse), 32'd1);
    chk("f3_cnt", 32'(u_if.fail_cnt), 32'd3);
    chk("f3_alarm", 32'(u_if.alarm), 32'd1);
    chk("f3_state", 32'(u_if.state), 32'd3);
    press4(16'h1234); press(4'hF);
    chk("lk_state", 32'(u_if.state), 32'd3);
    chk("lk_cnt", 32'(u_if.digit_cnt), 32'd0);
    chk("lk_unl", 32'(u_if.unlocked), 32'd0);
    repeat (int'(T_LOCK) - 6) @(negedge clk);
    chk("lk_last", 32'(u_if.alarm), 32'd1);
    @(negedge clk);
    chk("lk_exp_alarm", 32'(u_if.alarm), 32'd0);
    chk("lk_exp_state", 32'(u_if.state), 32'd0);
    chk("lk_exp_fail", 32'(u_if.fail_cnt), 32'd0);

    // Change passcode to 9876
    press4(16'h1234); press(4'hF);
    press(4'hA);
    chk("setpw_state", 32'(u_if.state), 32'd2);
    press(4'h5); press(4'hF);
    chk("setpw_short_err", 32'(u_if.err_pulse), 32'd1);
    chk("setpw_short_st", 32'(u_if.state), 32'd2);
    press(4'hE);
    press4(16'h9876); press(4'hF);
    chk("setd_pulse", 32'(u_if.set_done), 32'd1);
    chk("setd_state", 32'(u_if.state), 32'd0);
    chk("setd_entry", 32'(u_if.entry), 32'd0);
    press(4'hE);
    chk("setd_clr", 32'(u_if.set_done), 32'd0);
    press4(16'h1234); press(4'hF);
    chk("old_pw_err", 32'(u_if.err_pulse), 32'd1);
    chk("old_pw_fail", 32'(u_if.fail_cnt), 32'd1);
    press4(16'h9876); press(4'hF);
    chk("new_pw_unl", 32'(u_if.unlocked), 32'd1);
    chk("new_pw_fail", 32'(u_if.fail_cnt), 32'd0);

    // Abort SETPW with B keeps passcode
    press(4'hA);
    press4(16'h1111);
    press(4'hB);
    chk("abort_state", 32'(u_if.state), 32'd0);
    chk("abort_entry", 32'(u_if.entry), 32'd0);
    chk("abort_cnt", 32'(u_if.digit_cnt), 32'd0);
    press4(16'h9876); press(4'hF);
    chk("abort_pw", 32'(u_if.unlocked), 32'd1);

    // Reset in SETPW discards the new passcode and reverts to default
    press(4'hA);
    press4(16'h5555);
    do_reset();
    chk("rst2_state", 32'(u_if.state), 32'd0);
    chk("rst2_entry", 32'(u_if.entry), 32'd0);
    press4(16'h1234); press(4'hF);
    chk("rst2_pw", 32'(u_if.unlocked), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
